// File: rtl/md_unit_pkg.sv
// Shared op encodings, FSM states and default latency for the multiply/divide unit.
package md_unit_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5,
        MD_MADD  = 3'd6,
        MD_MSUB  = 3'd7
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } md_state_e;

    localparam int MUL_CYCLES_DEF = 5;

endpackage

// File: rtl/md_divider.sv
// Iterative radix-2 restoring unsigned divider: one quotient bit per cycle, WIDTH cycles.
// o_q/o_r present the final step combinationally in the cycle o_done is high.
module md_divider import md_unit_pkg::*; #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_q,
    output logic [WIDTH-1:0] o_r,
    output logic             o_done
);

    localparam int CNT_W = $clog2(WIDTH);

    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_div;
    logic [CNT_W-1:0] r_cnt;
    logic             r_act;

    logic [WIDTH:0]   w_sh;
    logic [WIDTH:0]   w_diff;
    logic             w_ge;
    logic [WIDTH-1:0] w_rem_nx;
    logic [WIDTH-1:0] w_quo_nx;

    // Partial remainder stays below the divisor, so WIDTH+1 bits hold the shifted trial.
    assign w_sh     = {r_rem, r_quo[WIDTH-1]};
    assign w_diff   = w_sh - {1'b0, r_div};
    assign w_ge     = ~w_diff[WIDTH];
    assign w_rem_nx = w_ge ? w_diff[WIDTH-1:0] : w_sh[WIDTH-1:0];
    assign w_quo_nx = {r_quo[WIDTH-2:0], w_ge};

    assign o_q    = w_quo_nx;
    assign o_r    = w_rem_nx;
    assign o_done = r_act && (r_cnt == '0);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rem <= '0;
            r_quo <= '0;
            r_div <= '0;
            r_cnt <= '0;
            r_act <= 1'b0;
        end else if (i_abort) begin
            r_act <= 1'b0;
        end else if (i_start) begin
            r_rem <= '0;
            r_quo <= i_dividend;
            r_div <= i_divisor;
            r_cnt <= CNT_W'(WIDTH - 1);
            r_act <= 1'b1;
        end else if (r_act) begin
            r_rem <= w_rem_nx;
            r_quo <= w_quo_nx;
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == '0)
                r_act <= 1'b0;
        end
    end

endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers beside the E-stage ALU.
// Optional MADD/MSUB accumulate ops are built only when MD_MADD_EN is defined.
module md_unit import md_unit_pkg::*; #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = MUL_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(MUL_CYCLES + 1);

    md_state_e        r_state;
    md_op_e           r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [CW-1:0]    r_cnt;

    md_op_e             w_op;
    logic               w_go;
    logic               w_is_mul;
    logic               w_is_div;
    logic [WIDTH-1:0]   w_dvd;
    logic [WIDTH-1:0]   w_dvs;
    logic [WIDTH-1:0]   w_q;
    logic [WIDTH-1:0]   w_r;
    logic               w_div_done;
    logic               w_sgn;
    logic [WIDTH-1:0]   w_div_hi;
    logic [WIDTH-1:0]   w_div_lo;
    logic [2*WIDTH-1:0] w_as;
    logic [2*WIDTH-1:0] w_bs;
    logic [2*WIDTH-1:0] w_prod_s;
    logic [2*WIDTH-1:0] w_prod_u;
    logic [2*WIDTH-1:0] w_mul_res;

    assign w_op = md_op_e'(op);
    assign w_go = start && !busy && !flush;

    always_comb begin
        w_is_mul = 1'b0;
        w_is_div = 1'b0;
        case (w_op)
            MD_MULT, MD_MULTU: w_is_mul = 1'b1;
`ifdef MD_MADD_EN
            MD_MADD, MD_MSUB:  w_is_mul = 1'b1;
`endif
            MD_DIV, MD_DIVU:   w_is_div = 1'b1;
            default: ;
        endcase
    end

    // The divider works on magnitudes; signs are restored from the latched operands.
    assign w_dvd = (w_op == MD_DIV && a[WIDTH-1]) ? -a : a;
    assign w_dvs = (w_op == MD_DIV && b[WIDTH-1]) ? -b : b;

    md_divider #(.WIDTH(WIDTH)) u_div (
        .i_clk      (clk),
        .i_rst_n    (reset),
        .i_start    (w_go && w_is_div),
        .i_abort    (flush),
        .i_dividend (w_dvd),
        .i_divisor  (w_dvs),
        .o_q        (w_q),
        .o_r        (w_r),
        .o_done     (w_div_done)
    );

    assign w_sgn = (r_op == MD_DIV);

    always_comb begin
        w_div_lo = (w_sgn && (r_a[WIDTH-1] ^ r_b[WIDTH-1])) ? -w_q : w_q;
        w_div_hi = (w_sgn && r_a[WIDTH-1]) ? -w_r : w_r;
        if (r_b == '0) begin
            w_div_lo = '1;
            w_div_hi = r_a;
        end else if (w_sgn && r_a == {1'b1, {(WIDTH-1){1'b0}}} && r_b == '1) begin
            w_div_lo = r_a;
            w_div_hi = '0;
        end
    end

    assign w_as     = {{WIDTH{r_a[WIDTH-1]}}, r_a};
    assign w_bs     = {{WIDTH{r_b[WIDTH-1]}}, r_b};
    assign w_prod_s = w_as * w_bs;
    assign w_prod_u = {{WIDTH{1'b0}}, r_a} * {{WIDTH{1'b0}}, r_b};

    always_comb begin
        case (r_op)
            MD_MULTU: w_mul_res = w_prod_u;
`ifdef MD_MADD_EN
            MD_MADD:  w_mul_res = {hi, lo} + w_prod_s;
            MD_MSUB:  w_mul_res = {hi, lo} - w_prod_s;
`endif
            default:  w_mul_res = w_prod_s;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_op    <= MD_MULT;
            r_a     <= '0;
            r_b     <= '0;
            r_cnt   <= '0;
            busy    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_go) begin
                        if (w_is_mul || w_is_div) begin
                            r_state <= w_is_mul ? ST_MUL : ST_DIV;
                            r_op    <= w_op;
                            r_a     <= a;
                            r_b     <= b;
                            r_cnt   <= CW'(MUL_CYCLES - 1);
                            busy    <= 1'b1;
                        end else if (w_op == MD_MTHI) begin
                            hi <= a;
                        end else if (w_op == MD_MTLO) begin
                            lo <= a;
                        end
                    end
                end
                ST_MUL: begin
                    if (flush) begin
                        r_state <= ST_IDLE;
                        busy    <= 1'b0;
                    end else if (r_cnt == '0) begin
                        {hi, lo} <= w_mul_res;
                        r_state  <= ST_IDLE;
                        busy     <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_DIV: begin
                    if (flush) begin
                        r_state <= ST_IDLE;
                        busy    <= 1'b0;
                    end else if (w_div_done) begin
                        hi      <= w_div_hi;
                        lo      <= w_div_lo;
                        r_state <= ST_IDLE;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
